// File: rtl/txrx_seq_pkg.sv
// Shared definitions for the transceiver sequencer: bus widths, channel index
// width and the transceiver register address map.
package txrx_seq_pkg;

  localparam int TXRX_ADDR_W = 8;
  localparam int CH_IDX_W    = 6;

  localparam logic [TXRX_ADDR_W-1:0] TXRX_AA           = 8'h00;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_CH_IDX       = 8'h04;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_TX_EN        = 8'h08;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_TX_DATA      = 8'h0C;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_TX_START     = 8'h10;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_TX_READY     = 8'h14;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_RX_EN        = 8'h18;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_DEMOD_EN     = 8'h1C;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_RX_START     = 8'h20;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_RX_AA_FOUND  = 8'h24;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_RX_DATA      = 8'h28;
  localparam logic [TXRX_ADDR_W-1:0] TXRX_RX_CRC_VALID = 8'h2C;

endpackage

// File: rtl/txrx_seq_bus.sv
// Single-access bus initiator. Handshake: m_valid rises with address, wdata and
// wstrb held stable; the access completes on the first cycle with m_ready=1,
// where m_rdata is captured, m_valid drops and done_o pulses on the next cycle.
module txrx_seq_bus
  import txrx_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [TXRX_ADDR_W-1:0] addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   done_o,
  output logic [31:0]            rdata_o,
  output logic                   m_valid,
  output logic [TXRX_ADDR_W-1:0] m_address,
  output logic [31:0]            m_wdata,
  output logic                   m_wstrb,
  input  logic [31:0]            m_rdata,
  input  logic                   m_ready
);

  logic                   m_valid_q;
  logic [TXRX_ADDR_W-1:0] addr_q;
  logic [31:0]            wdata_q;
  logic                   wstrb_q;
  logic [31:0]            rdata_q;
  logic                   done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 1'b0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (m_valid_q) begin
        if (m_ready) begin
          m_valid_q <= 1'b0;
          rdata_q   <= m_rdata;
          done_q    <= 1'b1;
        end
      end else if (req_i) begin
        // A request is only honoured from an idle bus, so m_valid is always
        // low for at least one cycle between accesses.
        m_valid_q <= 1'b1;
        addr_q    <= addr_i;
        wdata_q   <= we_i ? wdata_i : '0;
        wstrb_q   <= we_i;
      end
    end
  end

  assign m_valid   = m_valid_q;
  assign m_address = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign rdata_o   = rdata_q;
  assign done_o    = done_q;

endmodule

// File: rtl/txrx_seq.sv
// Transceiver packet sequencer: configures access address and channel, then
// runs the TX or RX register sequence over a single bus initiator.
module txrx_seq
  import txrx_seq_pkg::*;
#(
  parameter int LEN_W    = 6,
  parameter int POLL_MAX = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic                   cmd_tx,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [31:0]            cmd_aa,
  input  logic [CH_IDX_W-1:0]    cmd_ch,
  input  logic [7:0]             din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [7:0]             dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   m_valid,
  output logic [TXRX_ADDR_W-1:0] m_address,
  output logic [31:0]            m_wdata,
  output logic                   m_wstrb,
  input  logic [31:0]            m_rdata,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   crc_ok,
  output logic                   timeout,
  output logic [4:0]             dbg_state
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  typedef enum logic [4:0] {
    S_IDLE, S_CFG_AA, S_CFG_CH,
    S_TX_EN_ON, S_TX_DATA, S_TX_START1, S_TX_START0, S_TX_POLL, S_TX_EN_OFF,
    S_RX_EN_ON, S_DEMOD_ON, S_RX_START1, S_RX_START0, S_RX_POLL, S_RX_DATA,
    S_RX_CRC, S_DEMOD_OFF, S_RX_EN_OFF, S_DONE
  } state_t;

  state_t                state_q;
  logic                  wait_q, req_q, tx_q;
  logic [LEN_W-1:0]      cnt_q;
  logic [PW-1:0]         poll_q;
  logic [31:0]           aa_q;
  logic [CH_IDX_W-1:0]   ch_q;
  logic [7:0]            byte_q, dout_q;
  logic                  din_ready_q, dout_valid_q;
  logic                  busy_q, done_q, crc_ok_q, timeout_q;

  logic                   acc_we;
  logic [TXRX_ADDR_W-1:0] acc_addr;
  logic [31:0]            acc_wdata;
  logic                   bus_done;
  logic [31:0]            bus_rdata;
  logic                   unused_rdata;

  assign unused_rdata = ^bus_rdata[31:8];

  // Every busy state is one bus access; the state alone selects its target.
  always_comb begin
    acc_we    = 1'b1;
    acc_addr  = TXRX_AA;
    acc_wdata = '0;
    case (state_q)
      S_CFG_AA:    acc_wdata = aa_q;
      S_CFG_CH:    begin acc_addr = TXRX_CH_IDX;   acc_wdata = 32'(ch_q);         end
      S_TX_EN_ON:  begin acc_addr = TXRX_TX_EN;    acc_wdata = 32'd1;             end
      S_TX_DATA:   begin acc_addr = TXRX_TX_DATA;  acc_wdata = {24'd0, byte_q};   end
      S_TX_START1: begin acc_addr = TXRX_TX_START; acc_wdata = 32'd1;             end
      S_TX_START0: acc_addr = TXRX_TX_START;
      S_TX_POLL:   begin acc_addr = TXRX_TX_READY; acc_we = 1'b0;                 end
      S_TX_EN_OFF: acc_addr = TXRX_TX_EN;
      S_RX_EN_ON:  begin acc_addr = TXRX_RX_EN;    acc_wdata = 32'd1;             end
      S_DEMOD_ON:  begin acc_addr = TXRX_DEMOD_EN; acc_wdata = 32'd1;             end
      S_RX_START1: begin acc_addr = TXRX_RX_START; acc_wdata = 32'd1;             end
      S_RX_START0: acc_addr = TXRX_RX_START;
      S_RX_POLL:   begin acc_addr = TXRX_RX_AA_FOUND;  acc_we = 1'b0;             end
      S_RX_DATA:   begin acc_addr = TXRX_RX_DATA;      acc_we = 1'b0;             end
      S_RX_CRC:    begin acc_addr = TXRX_RX_CRC_VALID; acc_we = 1'b0;             end
      S_DEMOD_OFF: acc_addr = TXRX_DEMOD_EN;
      S_RX_EN_OFF: acc_addr = TXRX_RX_EN;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wait_q       <= 1'b0;
      req_q        <= 1'b0;
      tx_q         <= 1'b0;
      cnt_q        <= '0;
      poll_q       <= '0;
      aa_q         <= '0;
      ch_q         <= '0;
      byte_q       <= '0;
      dout_q       <= '0;
      din_ready_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crc_ok_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      if (dout_valid_q && dout_ready) dout_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          tx_q      <= cmd_tx;
          cnt_q     <= cmd_len;
          aa_q      <= cmd_aa;
          ch_q      <= cmd_ch;
          crc_ok_q  <= 1'b0;
          timeout_q <= 1'b0;
          busy_q    <= 1'b1;
          wait_q    <= 1'b0;
          state_q   <= S_CFG_AA;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: if (!wait_q) begin
          if (state_q == S_TX_DATA) begin
            if (din_ready_q && din_valid) begin
              byte_q      <= din;
              din_ready_q <= 1'b0;
              req_q       <= 1'b1;
              wait_q      <= 1'b1;
            end else begin
              din_ready_q <= 1'b1;
            end
          end else if (!(((state_q == S_RX_DATA) || (state_q == S_RX_CRC)) && dout_valid_q)) begin
            // RX reads hold off until the previous byte has been taken.
            req_q  <= 1'b1;
            wait_q <= 1'b1;
          end
        end else if (bus_done) begin
          wait_q <= 1'b0;
          case (state_q)
            S_CFG_AA:    state_q <= S_CFG_CH;
            S_CFG_CH:    state_q <= tx_q ? S_TX_EN_ON : S_RX_EN_ON;
            S_TX_EN_ON:  state_q <= (cnt_q == '0) ? S_TX_START1 : S_TX_DATA;
            S_TX_DATA: begin
              cnt_q <= cnt_q - 1'b1;
              if (cnt_q == LEN_W'(1)) state_q <= S_TX_START1;
            end
            S_TX_START1: state_q <= S_TX_START0;
            S_TX_START0: begin poll_q <= '0; state_q <= S_TX_POLL; end
            S_TX_POLL: begin
              if (bus_rdata[0]) state_q <= S_TX_EN_OFF;
              else if (poll_q == POLL_LAST) begin timeout_q <= 1'b1; state_q <= S_TX_EN_OFF; end
              else poll_q <= poll_q + 1'b1;
            end
            S_TX_EN_OFF: begin done_q <= 1'b1; state_q <= S_DONE; end
            S_RX_EN_ON:  state_q <= S_DEMOD_ON;
            S_DEMOD_ON:  state_q <= S_RX_START1;
            S_RX_START1: state_q <= S_RX_START0;
            S_RX_START0: begin poll_q <= '0; state_q <= S_RX_POLL; end
            S_RX_POLL: begin
              if (bus_rdata[0]) state_q <= (cnt_q == '0) ? S_RX_CRC : S_RX_DATA;
              else if (poll_q == POLL_LAST) begin timeout_q <= 1'b1; state_q <= S_DEMOD_OFF; end
              else poll_q <= poll_q + 1'b1;
            end
            S_RX_DATA: begin
              dout_q       <= bus_rdata[7:0];
              dout_valid_q <= 1'b1;
              cnt_q        <= cnt_q - 1'b1;
              if (cnt_q == LEN_W'(1)) state_q <= S_RX_CRC;
            end
            S_RX_CRC:    begin crc_ok_q <= bus_rdata[0]; state_q <= S_DEMOD_OFF; end
            S_DEMOD_OFF: state_q <= S_RX_EN_OFF;
            S_RX_EN_OFF: begin done_q <= 1'b1; state_q <= S_DONE; end
            default:     state_q <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  txrx_seq_bus u_bus (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_q),
    .we_i      (acc_we),
    .addr_i    (acc_addr),
    .wdata_i   (acc_wdata),
    .done_o    (bus_done),
    .rdata_o   (bus_rdata),
    .m_valid   (m_valid),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  assign din_ready  = din_ready_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign crc_ok     = crc_ok_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state_q;

endmodule
